// File: rtl/cc_player_car_collider_if.sv
// Row-beat bus between the player/car row generators and the collider stage.
// The master drives the row beat and control; the slave returns the composited row and status.
interface cc_player_car_collider_if #(
   parameter int DATAWIDTH = 8,
   parameter int ROWIDX_W  = 3,
   parameter int HITCNT_W  = 4
);
   logic                 CC_PLAYER_CAR_COLLIDER_Valid_In;
   logic [ROWIDX_W-1:0]  CC_PLAYER_CAR_COLLIDER_RowIdx_InBus;
   logic [DATAWIDTH-1:0] CC_PLAYER_CAR_COLLIDER_PlayerData_InBus;
   logic [DATAWIDTH-1:0] CC_PLAYER_CAR_COLLIDER_CarData_InBus;
   logic [1:0]           CC_PLAYER_CAR_COLLIDER_Mode_InBus;
   logic                 CC_PLAYER_CAR_COLLIDER_ClearHit_In;
   logic [DATAWIDTH-1:0] CC_PLAYER_CAR_COLLIDER_Data_OutBus;
   logic [ROWIDX_W-1:0]  CC_PLAYER_CAR_COLLIDER_RowIdx_OutBus;
   logic                 CC_PLAYER_CAR_COLLIDER_Valid_Out;
   logic                 CC_PLAYER_CAR_COLLIDER_RowHit_Out;
   logic                 CC_PLAYER_CAR_COLLIDER_Hit_Out;
   logic                 CC_PLAYER_CAR_COLLIDER_FrameDone_Out;
   logic                 CC_PLAYER_CAR_COLLIDER_FrameErr_Out;
   logic [HITCNT_W-1:0]  CC_PLAYER_CAR_COLLIDER_HitCount_OutBus;

   modport master (
      output CC_PLAYER_CAR_COLLIDER_Valid_In,
      output CC_PLAYER_CAR_COLLIDER_RowIdx_InBus,
      output CC_PLAYER_CAR_COLLIDER_PlayerData_InBus,
      output CC_PLAYER_CAR_COLLIDER_CarData_InBus,
      output CC_PLAYER_CAR_COLLIDER_Mode_InBus,
      output CC_PLAYER_CAR_COLLIDER_ClearHit_In,
      input  CC_PLAYER_CAR_COLLIDER_Data_OutBus,
      input  CC_PLAYER_CAR_COLLIDER_RowIdx_OutBus,
      input  CC_PLAYER_CAR_COLLIDER_Valid_Out,
      input  CC_PLAYER_CAR_COLLIDER_RowHit_Out,
      input  CC_PLAYER_CAR_COLLIDER_Hit_Out,
      input  CC_PLAYER_CAR_COLLIDER_FrameDone_Out,
      input  CC_PLAYER_CAR_COLLIDER_FrameErr_Out,
      input  CC_PLAYER_CAR_COLLIDER_HitCount_OutBus
   );

   modport slave (
      input  CC_PLAYER_CAR_COLLIDER_Valid_In,
      input  CC_PLAYER_CAR_COLLIDER_RowIdx_InBus,
      input  CC_PLAYER_CAR_COLLIDER_PlayerData_InBus,
      input  CC_PLAYER_CAR_COLLIDER_CarData_InBus,
      input  CC_PLAYER_CAR_COLLIDER_Mode_InBus,
      input  CC_PLAYER_CAR_COLLIDER_ClearHit_In,
      output CC_PLAYER_CAR_COLLIDER_Data_OutBus,
      output CC_PLAYER_CAR_COLLIDER_RowIdx_OutBus,
      output CC_PLAYER_CAR_COLLIDER_Valid_Out,
      output CC_PLAYER_CAR_COLLIDER_RowHit_Out,
      output CC_PLAYER_CAR_COLLIDER_Hit_Out,
      output CC_PLAYER_CAR_COLLIDER_FrameDone_Out,
      output CC_PLAYER_CAR_COLLIDER_FrameErr_Out,
      output CC_PLAYER_CAR_COLLIDER_HitCount_OutBus
   );
endinterface

// File: rtl/cc_player_car_collider.sv
// Registered player/car row compositor with overlap detection, frame sequencing,
// sticky hit flag, saturating collided-frame counter and blinking collision highlight.
module cc_player_car_collider #(
   parameter int DATAWIDTH    = 8,
   parameter int ROWS         = 8,
   parameter int ROWIDX_W     = 3,
   parameter int HITCNT_W     = 4,
   parameter int BLINK_FRAMES = 4
) (
   input logic                     CC_PLAYER_CAR_COLLIDER_CLOCK_50,
   input logic                     CC_PLAYER_CAR_COLLIDER_RESET_InHigh,
   cc_player_car_collider_if.slave bus
);
   localparam logic [0:0]          IDLE       = 1'b0;
   localparam logic [0:0]          SCAN       = 1'b1;
   localparam logic [ROWIDX_W-1:0] LAST_ROW   = ROWIDX_W'(ROWS - 1);
   localparam logic [ROWIDX_W-1:0] ROW_ONE    = ROWIDX_W'(1);
   localparam int                  BLINK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
   localparam logic [HITCNT_W-1:0] CNT_MAX    = '1;

   logic                 valid;
   logic [ROWIDX_W-1:0]  row;
   logic [DATAWIDTH-1:0] player;
   logic [DATAWIDTH-1:0] car;
   logic [1:0]           mode;
   logic                 clear_hit;

   assign valid     = bus.CC_PLAYER_CAR_COLLIDER_Valid_In;
   assign row       = bus.CC_PLAYER_CAR_COLLIDER_RowIdx_InBus;
   assign player    = bus.CC_PLAYER_CAR_COLLIDER_PlayerData_InBus;
   assign car       = bus.CC_PLAYER_CAR_COLLIDER_CarData_InBus;
   assign mode      = bus.CC_PLAYER_CAR_COLLIDER_Mode_InBus;
   assign clear_hit = bus.CC_PLAYER_CAR_COLLIDER_ClearHit_In;

   logic [0:0]           state_reg, state_next;
   logic [ROWIDX_W-1:0]  expected_reg, expected_next;
   logic                 frame_hit_reg, frame_hit_next;
   logic                 blink_phase_reg, blink_phase_next;
   logic [BLINK_W-1:0]   blink_cnt_reg, blink_cnt_next;
   logic [HITCNT_W-1:0]  hit_count_reg, hit_count_next;
   logic [DATAWIDTH-1:0] data_reg;
   logic [ROWIDX_W-1:0]  row_reg;
   logic                 valid_reg, row_hit_reg, hit_reg, done_reg, err_reg;

   logic [DATAWIDTH-1:0] ov;
   logic [DATAWIDTH-1:0] composite;
   logic                 row_hit;
   logic                 frame_done;
   logic                 frame_err;

   assign ov      = player & car;
   assign row_hit = |ov;

   // Highlight mode darkens overlapping pixels only during the odd blink phase.
   always_comb begin
      composite = player | car;
      case (mode)
         2'b00:   composite = player | car;
         2'b01:   composite = (player | car) & ~(blink_phase_reg ? ov : '0);
         2'b10:   composite = player;
         default: composite = car;
      endcase
   end

   always_comb begin
      state_next       = state_reg;
      expected_next    = expected_reg;
      frame_hit_next   = frame_hit_reg;
      blink_phase_next = blink_phase_reg;
      blink_cnt_next   = blink_cnt_reg;
      hit_count_next   = hit_count_reg;
      frame_done       = 1'b0;
      frame_err        = 1'b0;
      if (valid) begin
         case (state_reg)
            IDLE: begin
               if (row == '0) begin
                  state_next     = SCAN;
                  expected_next  = ROW_ONE;
                  frame_hit_next = row_hit;
               end
            end
            default: begin
               if (row == expected_reg) begin
                  if (expected_reg == LAST_ROW) begin
                     frame_done     = 1'b1;
                     state_next     = IDLE;
                     expected_next  = '0;
                     frame_hit_next = 1'b0;
                     if ((frame_hit_reg | row_hit) && hit_count_reg != CNT_MAX)
                        hit_count_next = hit_count_reg + 1'b1;
                     if (blink_cnt_reg == BLINK_LAST) begin
                        blink_cnt_next   = '0;
                        blink_phase_next = ~blink_phase_reg;
                     end else begin
                        blink_cnt_next = blink_cnt_reg + 1'b1;
                     end
                  end else begin
                     expected_next  = expected_reg + 1'b1;
                     frame_hit_next = frame_hit_reg | row_hit;
                  end
               end else begin
                  // Out-of-sequence row: a fresh row 0 restarts the frame in place.
                  frame_err = 1'b1;
                  if (row == '0) begin
                     expected_next  = ROW_ONE;
                     frame_hit_next = row_hit;
                  end else begin
                     state_next     = IDLE;
                     expected_next  = '0;
                     frame_hit_next = 1'b0;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge CC_PLAYER_CAR_COLLIDER_CLOCK_50 or posedge CC_PLAYER_CAR_COLLIDER_RESET_InHigh) begin
      if (CC_PLAYER_CAR_COLLIDER_RESET_InHigh) begin
         state_reg       <= IDLE;
         expected_reg    <= '0;
         frame_hit_reg   <= 1'b0;
         blink_phase_reg <= 1'b0;
         blink_cnt_reg   <= '0;
         hit_count_reg   <= '0;
         data_reg        <= '0;
         row_reg         <= '0;
         valid_reg       <= 1'b0;
         row_hit_reg     <= 1'b0;
         hit_reg         <= 1'b0;
         done_reg        <= 1'b0;
         err_reg         <= 1'b0;
      end else begin
         state_reg       <= state_next;
         expected_reg    <= expected_next;
         frame_hit_reg   <= frame_hit_next;
         blink_phase_reg <= blink_phase_next;
         blink_cnt_reg   <= blink_cnt_next;
         hit_count_reg   <= hit_count_next;
         valid_reg       <= valid;
         done_reg        <= frame_done;
         err_reg         <= frame_err;
         if (valid) begin
            data_reg    <= composite;
            row_reg     <= row;
            row_hit_reg <= row_hit;
         end
         // A new overlap outranks a simultaneous clear.
         if (valid && row_hit)
            hit_reg <= 1'b1;
         else if (clear_hit)
            hit_reg <= 1'b0;
      end
   end

   assign bus.CC_PLAYER_CAR_COLLIDER_Data_OutBus     = data_reg;
   assign bus.CC_PLAYER_CAR_COLLIDER_RowIdx_OutBus   = row_reg;
   assign bus.CC_PLAYER_CAR_COLLIDER_Valid_Out       = valid_reg;
   assign bus.CC_PLAYER_CAR_COLLIDER_RowHit_Out      = row_hit_reg;
   assign bus.CC_PLAYER_CAR_COLLIDER_Hit_Out         = hit_reg;
   assign bus.CC_PLAYER_CAR_COLLIDER_FrameDone_Out   = done_reg;
   assign bus.CC_PLAYER_CAR_COLLIDER_FrameErr_Out    = err_reg;
   assign bus.CC_PLAYER_CAR_COLLIDER_HitCount_OutBus = hit_count_reg;
endmodule

// File: tb/tb_cc_player_car_collider.sv
// Directed bench for cc_player_car_collider: a vector table for frame sequencing,
// plus hand sequences for blinking, counter saturation and mid-frame reset.
module tb_cc_player_car_collider;
   logic clk;
   logic rst;
   int   tests;
   int   failed;

   logic       v_in;
   logic [2:0] r_in;
   logic [7:0] p_in;
   logic [7:0] c_in;
   logic [1:0] m_in;
   logic       clr_in;

   cc_player_car_collider_if #(.DATAWIDTH(8), .ROWIDX_W(3), .HITCNT_W(4)) bus ();

   cc_player_car_collider #(
      .DATAWIDTH(8), .ROWS(8), .ROWIDX_W(3), .HITCNT_W(4), .BLINK_FRAMES(4)
   ) dut (
      .CC_PLAYER_CAR_COLLIDER_CLOCK_50    (clk),
      .CC_PLAYER_CAR_COLLIDER_RESET_InHigh(rst),
      .bus                                (bus.slave)
   );

   assign bus.CC_PLAYER_CAR_COLLIDER_Valid_In        = v_in;
   assign bus.CC_PLAYER_CAR_COLLIDER_RowIdx_InBus    = r_in;
   assign bus.CC_PLAYER_CAR_COLLIDER_PlayerData_InBus = p_in;
   assign bus.CC_PLAYER_CAR_COLLIDER_CarData_InBus   = c_in;
   assign bus.CC_PLAYER_CAR_COLLIDER_Mode_InBus      = m_in;
   assign bus.CC_PLAYER_CAR_COLLIDER_ClearHit_In     = clr_in;

   logic [7:0] o_data;
   logic [2:0] o_row;
   logic       o_valid, o_rowhit, o_hit, o_done, o_err;
   logic [3:0] o_cnt;

   assign o_data   = bus.CC_PLAYER_CAR_COLLIDER_Data_OutBus;
   assign o_row    = bus.CC_PLAYER_CAR_COLLIDER_RowIdx_OutBus;
   assign o_valid  = bus.CC_PLAYER_CAR_COLLIDER_Valid_Out;
   assign o_rowhit = bus.CC_PLAYER_CAR_COLLIDER_RowHit_Out;
   assign o_hit    = bus.CC_PLAYER_CAR_COLLIDER_Hit_Out;
   assign o_done   = bus.CC_PLAYER_CAR_COLLIDER_FrameDone_Out;
   assign o_err    = bus.CC_PLAYER_CAR_COLLIDER_FrameErr_Out;
   assign o_cnt    = bus.CC_PLAYER_CAR_COLLIDER_HitCount_OutBus;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       valid;
      logic [2:0] row;
      logic [7:0] player;
      logic [7:0] car;
      logic [1:0] mode;
      logic       clr;
      logic [7:0] e_data;
      logic [2:0] e_row;
      logic       e_rowhit;
      logic       e_done;
      logic       e_err;
      logic       e_hit;
      logic [3:0] e_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic v, input int r, input int p, input int c,
                               input int m, input logic clr, input int ed, input int er,
                               input logic erh, input logic edn, input logic eer,
                               input logic eh, input int ec);
      vec_t t;
      t.valid = v;      t.row = 3'(r);     t.player = 8'(p);  t.car = 8'(c);
      t.mode = 2'(m);   t.clr = clr;       t.e_data = 8'(ed); t.e_row = 3'(er);
      t.e_rowhit = erh; t.e_done = edn;    t.e_err = eer;     t.e_hit = eh;
      t.e_cnt = 4'(ec);
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic beat(input logic v, input int r, input int p, input int c,
                       input int m, input logic clr);
      @(negedge clk);
      v_in = v; r_in = 3'(r); p_in = 8'(p); c_in = 8'(c); m_in = 2'(m); clr_in = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      v_in = 1'b0; clr_in = 1'b0; rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      tests = 0; failed = 0;
      rst = 1'b1; v_in = 1'b0; r_in = '0; p_in = '0; c_in = '0; m_in = '0; clr_in = 1'b0;

      // Frame A: no overlap, row 7 composites 0x10|0x0F
      for (int r = 0; r < 8; r++)
         vecs.push_back(mk(1, r, (r == 7) ? 8'h10 : 0, 8'h0F, 0, 0,
                           (r == 7) ? 8'h1F : 8'h0F, r, 0, r == 7, 0, 0, 0));
      // Frame B: overlap on row 3
      for (int r = 0; r < 8; r++)
         vecs.push_back(mk(1, r, (r == 3) ? 8'h04 : 0, 8'h0F, 0, 0,
                           8'h0F, r, r == 3, r == 7, 0, r >= 3, (r == 7) ? 1 : 0));
      // Idle ClearHit: outputs hold, flag drops
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 8'h0F, 7, 0, 0, 0, 0, 1));
      // ClearHit with a new overlap: set wins
      vecs.push_back(mk(1, 0, 8'h01, 8'h01, 0, 1, 8'h01, 0, 1, 0, 0, 1, 1));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1));
      vecs.push_back(mk(1, 2, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 1));
      vecs.push_back(mk(1, 5, 0, 0, 0, 0, 0, 5, 0, 0, 1, 1, 1));
      // Restart on repeated row 0; the earlier overlap must be discarded
      vecs.push_back(mk(1, 0, 8'h80, 8'h80, 0, 0, 8'h80, 0, 1, 0, 0, 1, 1));
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
      for (int r = 1; r < 8; r++)
         vecs.push_back(mk(1, r, 0, 0, 0, 0, 0, r, 0, r == 7, 0, 1, 1));
      // Rows while idle are composited only
      for (int r = 3; r < 8; r++)
         vecs.push_back(mk(1, r, 8'h02, 8'h20, 0, 0, 8'h22, r, 0, 0, 0, 1, 1));
      vecs.push_back(mk(1, 3, 8'h0A, 8'h30, 2, 0, 8'h0A, 3, 0, 0, 0, 1, 1));
      vecs.push_back(mk(1, 4, 8'h0A, 8'h30, 3, 0, 8'h30, 4, 0, 0, 0, 1, 1));
      vecs.push_back(mk(1, 5, 8'h3C, 8'h0F, 1, 0, 8'h3F, 5, 1, 0, 0, 1, 1));

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_data", 32'(o_data), 0);
      chk("rst_valid", 32'(o_valid), 0);
      chk("rst_hit", 32'(o_hit), 0);
      chk("rst_cnt", 32'(o_cnt), 0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         beat(vecs[i].valid, int'(vecs[i].row), int'(vecs[i].player), int'(vecs[i].car),
              int'(vecs[i].mode), vecs[i].clr);
         $display("[TB] vec %0d v=%0b row=%0d p=%02h c=%02h m=%0d -> data=%02h rh=%0b hit=%0b done=%0b err=%0b cnt=%0d",
                  i, vecs[i].valid, vecs[i].row, vecs[i].player, vecs[i].car, vecs[i].mode,
                  o_data, o_rowhit, o_hit, o_done, o_err, o_cnt);
         chk($sformatf("v%0d_valid", i), 32'(o_valid), 32'(vecs[i].valid));
         chk($sformatf("v%0d_data", i), 32'(o_data), 32'(vecs[i].e_data));
         chk($sformatf("v%0d_row", i), 32'(o_row), 32'(vecs[i].e_row));
         chk($sformatf("v%0d_rowhit", i), 32'(o_rowhit), 32'(vecs[i].e_rowhit));
         chk($sformatf("v%0d_done", i), 32'(o_done), 32'(vecs[i].e_done));
         chk($sformatf("v%0d_err", i), 32'(o_err), 32'(vecs[i].e_err));
         chk($sformatf("v%0d_hit", i), 32'(o_hit), 32'(vecs[i].e_hit));
         chk($sformatf("v%0d_cnt", i), 32'(o_cnt), 32'(vecs[i].e_cnt));
      end

      // Blink: highlight mode darkens the overlap in frames 5..8
      do_reset();
      for (int f = 0; f < 8; f++) begin
         for (int r = 0; r < 8; r++) begin
            beat(1, r, (r == 3) ? 8'h04 : 0, 8'h0F, 1, 0);
            if (r == 3) begin
               $display("[TB] blink frame %0d row 3 data=%02h", f + 1, o_data);
               chk($sformatf("blink_f%0d", f + 1), 32'(o_data), (f < 4) ? 32'h0F : 32'h0B);
            end
         end
         chk($sformatf("blink_done_f%0d", f + 1), 32'(o_done), 1);
      end
      chk("blink_cnt", 32'(o_cnt), 8);

      // Saturation of the collided-frame counter
      do_reset();
      for (int f = 0; f < 20; f++) begin
         for (int r = 0; r < 8; r++)
            beat(1, r, (r == 0) ? 1 : 0, (r == 0) ? 1 : 0, 0, 0);
         $display("[TB] sat frame %0d cnt=%0d", f + 1, o_cnt);
         chk($sformatf("sat_f%0d", f + 1), 32'(o_cnt), (f + 1 > 15) ? 15 : 32'(f + 1));
      end

      // Asynchronous reset in the middle of a collided frame
      do_reset();
      for (int r = 0; r < 5; r++)
         beat(1, r, (r == 2) ? 8'hFF : 0, (r == 2) ? 8'hFF : 0, 0, 0);
      chk("mid_hit_pre", 32'(o_hit), 1);
      chk("mid_data_pre", 32'(o_row), 4);
      #2 rst = 1'b1;
      #1;
      $display("[TB] async reset data=%02h row=%0d v=%0b hit=%0b cnt=%0d", o_data, o_row, o_valid, o_hit, o_cnt);
      chk("mid_rst_row", 32'(o_row), 0);
      chk("mid_rst_valid", 32'(o_valid), 0);
      chk("mid_rst_rowhit", 32'(o_rowhit), 0);
      chk("mid_rst_hit", 32'(o_hit), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int r = 5; r < 8; r++) begin
         beat(1, r, 8'h01, 8'h02, 0, 0);
         chk($sformatf("mid_r%0d_data", r), 32'(o_data), 32'h03);
         chk($sformatf("mid_r%0d_done", r), 32'(o_done), 0);
         chk($sformatf("mid_r%0d_err", r), 32'(o_err), 0);
      end
      chk("mid_cnt", 32'(o_cnt), 0);

      @(negedge clk);
      v_in = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/cc_player_car_collider.md
Name: cc_player_car_collider

Overview:
- Parametrised, registered successor to the row-combiner stage between the player and car row generators and the LED-matrix row driver.
- Accepts one matrix row per valid beat: player bits and car bits for that row index.
- Emits the composited row one cycle later, using a selectable display mode.
- Detects player/car overlap per row, tracks frame sequencing, keeps a sticky hit flag and a saturating count of collided frames, and blinks collision pixels in highlight mode.

Parameters:
- DATAWIDTH, 8: columns per row.
- ROWS, 8: rows per frame. Must be ≥ 2.
- ROWIDX_W, 3: row-index width. Must satisfy ROWS ≤ 2^ROWIDX_W.
- HITCNT_W, 4: width of the collided-frame counter.
- BLINK_FRAMES, 4: completed frames per blink half-period. Must be ≥ 1.

Ports:
- CC_PLAYER_CAR_COLLIDER_CLOCK_50, input, 1: system clock, rising edge.
- CC_PLAYER_CAR_COLLIDER_RESET_InHigh, input, 1: asynchronous, active-high reset.
- CC_PLAYER_CAR_COLLIDER_Valid_In, input, 1: row beat valid.
- CC_PLAYER_CAR_COLLIDER_RowIdx_InBus, input, ROWIDX_W: row index of the beat.
- CC_PLAYER_CAR_COLLIDER_PlayerData_InBus, input, DATAWIDTH: player pixels.
- CC_PLAYER_CAR_COLLIDER_CarData_InBus, input, DATAWIDTH: car pixels.
- CC_PLAYER_CAR_COLLIDER_Mode_InBus, input, 2: 00 OR, 01 collision-highlight, 10 player only, 11 cars only.
- CC_PLAYER_CAR_COLLIDER_ClearHit_In, input, 1: clears the sticky hit flag.
- CC_PLAYER_CAR_COLLIDER_Data_OutBus, output, DATAWIDTH: composited row.
- CC_PLAYER_CAR_COLLIDER_RowIdx_OutBus, output, ROWIDX_W: row index aligned with Data_OutBus.
- CC_PLAYER_CAR_COLLIDER_Valid_Out, output, 1: output beat valid.
- CC_PLAYER_CAR_COLLIDER_RowHit_Out, output, 1: the output row had overlap.
- CC_PLAYER_CAR_COLLIDER_Hit_Out, output, 1: sticky collision flag.
- CC_PLAYER_CAR_COLLIDER_FrameDone_Out, output, 1: one-cycle pulse at the end of a complete frame.
- CC_PLAYER_CAR_COLLIDER_FrameErr_Out, output, 1: one-cycle pulse on an out-of-sequence row.
- CC_PLAYER_CAR_COLLIDER_HitCount_OutBus, output, HITCNT_W: count of collided frames, saturating.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs go to 0.
  - FSM goes to IDLE; expected row = 0; frame_hit = 0; blink phase = 0; blink frame counter = 0.
  - Reset asserted mid-frame abandons the frame silently: no FrameDone and no FrameErr.
- Datapath (1-cycle latency, no backpressure, every valid beat accepted):
  - Valid_Out is Valid_In delayed one cycle.
  - Data_OutBus, RowIdx_OutBus and RowHit_Out update only on valid beats and hold otherwise.
  - Define ov = Player & Car.
  - RowHit = |ov.
  - Mode 00: Player | Car.
  - Mode 01: (Player | Car) & ~(ov masked by blink phase). Collision pixels are dark while phase = 1.
  - Mode 10: Player.
  - Mode 11: Car.
- Sticky hit flag:
  - Set on any valid beat with |ov.
  - Cleared by ClearHit_In.
  - If set and clear occur in the same cycle, set wins.
- FSM, evaluated on valid beats only:
  - IDLE, RowIdx == 0 → SCAN; expected = 1; frame_hit = |ov.
  - IDLE, any other RowIdx → stay IDLE. The row is still composited, but there is no frame accounting and no FrameErr.
  - SCAN, RowIdx == expected and expected < ROWS-1 → expected++; frame_hit |= |ov.
  - SCAN, RowIdx == expected == ROWS-1 → frame end:
    - FrameDone pulses.
    - If (frame_hit | |ov), HitCount increments, saturating at 2^HITCNT_W-1.
    - Blink frame counter increments; when it reaches BLINK_FRAMES it wraps to 0 and the blink phase toggles.
    - Next state IDLE.
  - SCAN, RowIdx ≠ expected → FrameErr pulses and frame_hit is discarded.
    - If RowIdx == 0, restart: stay SCAN, expected = 1, frame_hit = |ov.
    - Otherwise go to IDLE.
- Pulse alignment: FrameDone and FrameErr assert in the same cycle as Valid_Out for the causing beat.
- HitCount and the blink phase change only at frame end. Mode may change on any beat and takes effect on that beat's output.

Test Plan:
- Mode 00, one frame of rows 0..7, Player = 0x10 on row 7 only, Car = 0x0F on every row:
  - Row 7 outputs 0x1F one cycle after input.
  - No RowHit, FrameDone pulses once, HitCount stays 0, Hit_Out stays 0.
- Same frame, row 3 with Player = 0x04 and Car = 0x0F:
  - Row 3 outputs 0x0F with RowHit = 1.
  - Hit_Out = 1 from the next cycle; HitCount = 1 after row 7.
  - ClearHit pulse drops Hit_Out. ClearHit coincident with a new overlap keeps Hit_Out = 1.
- Mode 01, the overlapping row 3 repeated over 8 complete frames with BLINK_FRAMES = 4:
  - Outputs 0x0F in frames 1-4 and 0x0B in frames 5-8.
- Row sequence 0,1,2,5 → FrameErr pulses on row 5, FSM returns to IDLE, no FrameDone.
- Row sequence 0,1,0,1..7 → FrameErr on the second 0, then FrameDone after row 7.
- 20 collided frames with HITCNT_W = 4 → HitCount saturates at 15.
- Reset asserted after row 4 of a collided frame → all outputs go to 0 immediately, with no FrameDone.
- Rows 3..7 sent while idle → rows are composited, with no FrameDone and no FrameErr.
